// File: rtl/i2s_frame_tx.sv
// N-channel I2S / left-justified / TDM serial audio transmitter.
// Samples are staged per frame on a valid/ready stream and replayed next frame.
module i2s_frame_tx #(
  parameter int DW       = 24,
  parameter int SW       = 32,
  parameter int NCH      = 2,
  parameter int SCLK_DIV = 4,
  parameter int MODE     = 0,
  parameter int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic [CW-1:0] s_chan,
  output logic          underrun,
  output logic          sclk,
  output logic          lrclk,
  output logic          sdo
);

  localparam int DVW = $clog2(SCLK_DIV);
  localparam int BW  = (SW > 1) ? $clog2(SW) : 1;
  localparam int NW  = $clog2(NCH + 1);

  localparam logic [DVW-1:0] DIV_LAST  = DVW'(SCLK_DIV - 1);
  localparam logic [DVW-1:0] DIV_MID   = DVW'(SCLK_DIV / 2 - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(SW - 1);
  localparam logic [CW-1:0]  SLOT_LAST = CW'(NCH - 1);
  localparam logic [CW-1:0]  SLOT_HALF = CW'(NCH / 2);
  localparam logic [NW-1:0]  CNT_FULL  = NW'(NCH);

  logic [DVW-1:0] r_div;
  logic [BW-1:0]  r_bit;
  logic [CW-1:0]  r_slot;
  logic [NW-1:0]  r_cnt;
  logic [DW-1:0]  r_stage [NCH];
  logic [DW-1:0]  r_shift [NCH];
  logic           r_sclk;
  logic           r_lrclk;
  logic           r_sdo;
  logic           r_dly;
  logic           r_under;

  logic           w_wrap;
  logic           w_bit_end;
  logic           w_slot_end;
  logic           w_bnd;
  logic           w_full;
  logic           w_accept;
  logic [BW-1:0]  w_nbit;
  logic [CW-1:0]  w_nslot;
  logic           w_raw_nxt;
  logic           w_lr_half;
  logic           w_lr_sync;
  logic           w_lr_nxt;

  assign w_wrap     = (r_div == DIV_LAST);
  assign w_bit_end  = (r_bit == BIT_LAST);
  assign w_slot_end = (r_slot == SLOT_LAST);
  assign w_bnd      = w_wrap & w_bit_end & w_slot_end;
  assign w_full     = (r_cnt == CNT_FULL);
  assign w_accept   = s_valid & s_ready;

  assign w_nbit  = w_bit_end ? '0 : r_bit + 1'b1;
  assign w_nslot = !w_bit_end ? r_slot :
                   (w_slot_end ? '0 : r_slot + 1'b1);

  // At the boundary the new frame's first bit comes from what is about to load.
  always_comb begin
    w_raw_nxt = 1'b0;
    if (w_bnd) begin
      w_raw_nxt = w_full & r_stage[0][DW-1];
    end else begin
      for (int j = 0; j < DW; j++) begin
        if (w_nbit == BW'(j)) w_raw_nxt = r_shift[w_nslot][DW-1-j];
      end
    end
  end

  assign w_lr_half = (w_nslot >= SLOT_HALF);
  assign w_lr_sync = (w_nslot == '0) && (w_nbit == '0);
  assign w_lr_nxt  = (MODE == 2) ? w_lr_sync : w_lr_half;

  assign s_ready  = !rst & !w_full & !w_bnd;
  assign s_chan   = r_cnt[CW-1:0];
  assign underrun = r_under;
  assign sclk     = r_sclk;
  assign lrclk    = r_lrclk;
  assign sdo      = r_sdo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_slot  <= '0;
      r_cnt   <= '0;
      r_sclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_sdo   <= 1'b0;
      r_dly   <= 1'b0;
      r_under <= 1'b0;
      for (int k = 0; k < NCH; k++) r_shift[k] <= '0;
    end else begin
      r_under <= 1'b0;
      r_div   <= w_wrap ? '0 : r_div + 1'b1;
      if (r_div == DIV_MID) r_sclk <= 1'b1;
      if (w_wrap) begin
        r_sclk  <= 1'b0;
        r_bit   <= w_nbit;
        r_slot  <= w_nslot;
        r_lrclk <= w_lr_nxt;
        r_dly   <= w_raw_nxt;
        r_sdo   <= (MODE == 1) ? w_raw_nxt : r_dly;
      end
      if (w_bnd) begin
        r_cnt   <= '0;
        r_under <= !w_full;
        for (int k = 0; k < NCH; k++) begin
          r_shift[k] <= w_full ? r_stage[k] : '0;
        end
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_stage[r_cnt[CW-1:0]] <= s_data;
  end

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Directed bench for i2s_frame_tx: I2S, left-justified and TDM instances.
// Bit timing is tracked from reset release by a free cycle counter.
module tb_i2s_frame_tx;

  localparam int FL  = 256;
  localparam int FL2 = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int t = 0;
  always @(posedge clk) t <= rst ? 0 : t + 1;

  logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [23:0] d0 = '0, d1 = '0, d2 = '0;
  logic        rd0, rd1, rd2;
  logic        ch0, ch1;
  logic [2:0]  ch2;
  logic        un0, un1, un2;
  logic        sc0, sc1, sc2;
  logic        lr0, lr1, lr2;
  logic        so0, so1, so2;

  int total = 0;
  int bad   = 0;

  i2s_frame_tx u0 (
    .clk(clk), .rst(rst), .s_valid(v0), .s_ready(rd0),
    .s_data(d0), .s_chan(ch0), .underrun(un0),
    .sclk(sc0), .lrclk(lr0), .sdo(so0)
  );

  i2s_frame_tx #(.MODE(1)) u1 (
    .clk(clk), .rst(rst), .s_valid(v1), .s_ready(rd1),
    .s_data(d1), .s_chan(ch1), .underrun(un1),
    .sclk(sc1), .lrclk(lr1), .sdo(so1)
  );

  i2s_frame_tx #(.NCH(8), .MODE(2)) u2 (
    .clk(clk), .rst(rst), .s_valid(v2), .s_ready(rd2),
    .s_data(d2), .s_chan(ch2), .underrun(un2),
    .sclk(sc2), .lrclk(lr2), .sdo(so2)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: sim time exceeded, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] model(input int nch, input int mode,
                                         input logic [23:0] d [8]);
    logic [255:0] raw;
    raw = '0;
    for (int k = 0; k < nch; k++)
      for (int j = 0; j < 24; j++)
        raw[k*32+j] = d[k][23-j];
    if (mode == 1) return raw;
    return raw << 1;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [23:0] d);
    case (sel)
      0:       begin v0 = v; d0 = d; end
      1:       begin v1 = v; d1 = d; end
      default: begin v2 = v; d2 = d; end
    endcase
  endtask

  function automatic logic ready_of(input int sel);
    case (sel)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  task automatic sample(input int sel, output logic sc, output logic l,
                        output logic s, output logic u);
    case (sel)
      0:       begin sc = sc0; l = lr0; s = so0; u = un0; end
      1:       begin sc = sc1; l = lr1; s = so1; u = un1; end
      default: begin sc = sc2; l = lr2; s = so2; u = un2; end
    endcase
  endtask

  task automatic wait_phase(input int fl, input int ph);
    int n = 0;
    while (t % fl != ph && n < 4000) begin @(negedge clk); n++; end
    total++;
    if (n >= 4000) begin
      bad++;
      $display("FAIL wait_phase: got=timeout want=phase %0d", ph);
    end
  endtask

  task automatic push(input int sel, input logic [23:0] d);
    int n = 0;
    drive(sel, 1'b1, d);
    #1;
    while (!ready_of(sel) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL push%0d: s_ready got=0 want=1", sel);
    end
    @(negedge clk);
    drive(sel, 1'b0, '0);
  endtask

  task automatic capture(input int sel, output logic [255:0] sd,
                         output logic [255:0] lr, output int tbad,
                         output int und, output int upos);
    int fl, n;
    logic sc, l, s, u, ps, pl;
    fl = (sel == 2) ? FL2 : FL;
    sd = '0; lr = '0; tbad = 0; und = 0; upos = -1; n = 0;
    ps = 1'b0; pl = 1'b0;
    while (t % fl != 0 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) tbad++;
    for (int c = 0; c < fl; c++) begin
      if (c > 0) @(negedge clk);
      sample(sel, sc, l, s, u);
      if (sc !== ((c % 4) >= 2)) tbad++;
      if (c > 0 && (c % 4) != 0 && (s !== ps || l !== pl)) tbad++;
      if (c % 4 == 2) begin
        sd[c/4] = s;
        lr[c/4] = l;
      end
      if (u === 1'b1) begin
        und++;
        if (upos < 0) upos = c;
      end
      ps = s;
      pl = l;
    end
  endtask

  task automatic test_reset();
    logic [255:0] sd, lr;
    int tb, und, up;
    repeat (3) @(negedge clk);
    total++;
    if ({sc0, lr0, so0, un0, rd0, ch0} !== 6'b0) begin
      bad++;
      $display("FAIL reset_pins: got=%b want=000000",
               {sc0, lr0, so0, un0, rd0, ch0});
    end
    total++;
    if ({sc2, lr2, so2, un2, rd2, ch2} !== 8'b0) begin
      bad++;
      $display("FAIL reset_tdm: got=%b want=0", {sc2, lr2, so2, un2, rd2, ch2});
    end
    rst = 1'b0;
    push(0, 24'h111111);
    push(0, 24'h222222);
    wait_phase(FL, 100);
    push(0, 24'h333333);
    total++;
    if (ch0 !== 1'b1) begin
      bad++;
      $display("FAIL half_chan: got=%b want=1", ch0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({sc0, lr0, so0, un0, rd0, ch0} !== 6'b0) begin
      bad++;
      $display("FAIL midreset_pins: got=%b want=000000",
               {sc0, lr0, so0, un0, rd0, ch0});
    end
    rst = 1'b0;
    fork
      capture(0, sd, lr, tb, und, up);
      begin
        push(0, 24'hA5A5A5);
        push(0, 24'h3C3C3C);
      end
    join
    total++;
    if (sd !== '0) begin
      bad++;
      $display("FAIL first_frame_sdo: got=%h want=0", sd[63:0]);
    end
    total++;
    if (und !== 0) begin
      bad++;
      $display("FAIL first_frame_underrun: got=%0d want=0", und);
    end
    total++;
    if (lr[63:0] !== 64'hFFFFFFFF_00000000) begin
      bad++;
      $display("FAIL first_frame_lrclk: got=%h want=ffffffff00000000", lr[63:0]);
    end
    total++;
    if (tb !== 0) begin
      bad++;
      $display("FAIL first_frame_timing: got=%0d want=0", tb);
    end
  endtask

  task automatic test_i2s();
    logic [255:0] sd, lr, exp;
    logic [23:0] dv [8];
    int tb, und, up;
    dv = '{24'hA5A5A5, 24'h3C3C3C, 0, 0, 0, 0, 0, 0};
    exp = model(2, 0, dv);
    fork
      capture(0, sd, lr, tb, und, up);
      begin
        push(0, 24'h7FFFFF);
        total++;
        if (ch0 !== 1'b1) begin
          bad++;
          $display("FAIL i2s_chan: got=%b want=1", ch0);
        end
      end
    join
    total++;
    if (sd !== exp) begin
      bad++;
      $display("FAIL i2s_sdo: got=%h want=%h", sd[63:0], exp[63:0]);
    end
    total++;
    if (lr[63:0] !== 64'hFFFFFFFF_00000000) begin
      bad++;
      $display("FAIL i2s_lrclk: got=%h want=ffffffff00000000", lr[63:0]);
    end
    total++;
    if (sd[4:0] !== 5'b01010) begin
      bad++;
      $display("FAIL i2s_msb0: got=%b want=01010", sd[4:0]);
    end
    total++;
    if (sd[36:33] !== 4'b1100) begin
      bad++;
      $display("FAIL i2s_msb1: got=%b want=1100", sd[36:33]);
    end
    total++;
    if (sd[32:25] !== 8'h00 || sd[63:57] !== 7'h00) begin
      bad++;
      $display("FAIL i2s_pad: got=%h/%h want=0/0", sd[32:25], sd[63:57]);
    end
    total++;
    if (tb !== 0 || und !== 0) begin
      bad++;
      $display("FAIL i2s_timing: got=%0d/%0d want=0/0", tb, und);
    end
  endtask

  task automatic test_underrun();
    logic [255:0] sd, lr;
    int tb, und, up;
    fork
      capture(0, sd, lr, tb, und, up);
      begin
        wait_phase(FL, 1);
        total++;
        if (ch0 !== 1'b0) begin
          bad++;
          $display("FAIL under_chan: got=%b want=0", ch0);
        end
        push(0, 24'h800001);
        push(0, 24'h000FFF);
      end
    join
    total++;
    if (und !== 1 || up !== 0) begin
      bad++;
      $display("FAIL under_pulse: got=%0d@%0d want=1@0", und, up);
    end
    total++;
    if (sd !== '0) begin
      bad++;
      $display("FAIL under_silent: got=%h want=0", sd[63:0]);
    end
    total++;
    if (tb !== 0) begin
      bad++;
      $display("FAIL under_timing: got=%0d want=0", tb);
    end
  endtask

  task automatic test_recover();
    logic [255:0] sd, lr, exp;
    logic [23:0] dv [8];
    int tb, und, up;
    dv = '{24'h800001, 24'h000FFF, 0, 0, 0, 0, 0, 0};
    exp = model(2, 0, dv);
    capture(0, sd, lr, tb, und, up);
    total++;
    if (sd !== exp) begin
      bad++;
      $display("FAIL recover_sdo: got=%h want=%h", sd[63:0], exp[63:0]);
    end
    total++;
    if (und !== 0 || tb !== 0) begin
      bad++;
      $display("FAIL recover_flags: got=%0d/%0d want=0/0", und, tb);
    end
  endtask

  task automatic test_lj();
    logic [255:0] sd, lr, exp;
    logic [23:0] dv [8];
    int tb, und, up;
    dv = '{24'hA5A5A5, 24'h3C3C3C, 0, 0, 0, 0, 0, 0};
    exp = model(2, 1, dv);
    wait_phase(FL, 1);
    push(1, 24'hA5A5A5);
    push(1, 24'h3C3C3C);
    capture(1, sd, lr, tb, und, up);
    total++;
    if (sd !== exp) begin
      bad++;
      $display("FAIL lj_sdo: got=%h want=%h", sd[63:0], exp[63:0]);
    end
    total++;
    if (lr[63:0] !== 64'hFFFFFFFF_00000000) begin
      bad++;
      $display("FAIL lj_lrclk: got=%h want=ffffffff00000000", lr[63:0]);
    end
    total++;
    if (sd[3:0] !== 4'b0101 || sd[35:32] !== 4'b1100) begin
      bad++;
      $display("FAIL lj_msb: got=%b/%b want=0101/1100", sd[3:0], sd[35:32]);
    end
    total++;
    if (tb !== 0) begin
      bad++;
      $display("FAIL lj_timing: got=%0d want=0", tb);
    end
  endtask

  task automatic test_tdm();
    logic [255:0] sd, lr, exp;
    logic [23:0] dv [8];
    int tb, und, up;
    for (int k = 0; k < 8; k++) dv[k] = 24'(k + 1);
    exp = model(8, 2, dv);
    wait_phase(FL2, 1);
    for (int k = 0; k < 8; k++) push(2, 24'(k + 1));
    capture(2, sd, lr, tb, und, up);
    total++;
    if (sd !== exp) begin
      bad++;
      $display("FAIL tdm_sdo: got=%h want=%h", sd, exp);
    end
    total++;
    if (lr !== 256'h1) begin
      bad++;
      $display("FAIL tdm_fsync: got=%h want=1", lr);
    end
    total++;
    if (sd[24] !== 1'b1 || sd[56:55] !== 2'b01 || sd[248:245] !== 4'b0001) begin
      bad++;
      $display("FAIL tdm_lsb: got=%b/%b/%b want=1/01/0001",
               sd[24], sd[56:55], sd[248:245]);
    end
    total++;
    if (tb !== 0) begin
      bad++;
      $display("FAIL tdm_timing: got=%0d want=0", tb);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] accq [$];
    logic [23:0] nxt;
    logic [23:0] dv [8];
    logic [255:0] sd, lr, exp;
    int nacc [4];
    int bnd_err, tb, und, up, frm_bad;
    nxt = 24'h5A0F01;
    bnd_err = 0;
    frm_bad = 0;
    for (int f = 0; f < 4; f++) nacc[f] = 0;
    wait_phase(FL, 0);
    fork
      begin
        for (int c = 0; c < 4 * FL; c++) begin
          drive(0, 1'b1, nxt);
          #1;
          if (rd0 === 1'b1) begin
            if (c % FL == FL - 1) bnd_err++;
            accq.push_back(nxt);
            nacc[c/FL]++;
            nxt = nxt + 24'h0F1E2D;
          end
          @(negedge clk);
        end
        drive(0, 1'b0, '0);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          capture(0, sd, lr, tb, und, up);
          dv = '{0, 0, 0, 0, 0, 0, 0, 0};
          if (accq.size() >= 2 * i + 2) begin
            dv[0] = accq[2*i];
            dv[1] = accq[2*i+1];
          end
          exp = model(2, 0, dv);
          if (sd !== exp || accq.size() < 2 * i + 2) frm_bad++;
        end
      end
    join
    for (int f = 0; f < 4; f++) begin
      total++;
      if (nacc[f] !== 2) begin
        bad++;
        $display("FAIL bp_accepts[%0d]: got=%0d want=2", f, nacc[f]);
      end
    end
    total++;
    if (bnd_err !== 0) begin
      bad++;
      $display("FAIL bp_boundary_ready: got=%0d want=0", bnd_err);
    end
    total++;
    if (frm_bad !== 0) begin
      bad++;
      $display("FAIL bp_frames: got=%0d bad frames want=0", frm_bad);
    end
  endtask

  initial begin
    test_reset();
    test_i2s();
    test_underrun();
    test_recover();
    test_lj();
    test_tdm();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
